// File: rtl/tsc_dump_rx.sv
// Host-side receiver for the transient signal capture block. It requests a dump
// on a trigger-done edge, deserialises the framed bytes and holds them in a local RAM.
module tsc_dump_rx #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trd,
    input  logic          cd,
    input  logic          sd,
    output logic          sbf,
    input  logic          clr,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          valid,
    output logic          err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        WAIT_START = 3'd2,
        SHIFT      = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW:0]   count_nxt;
    logic          err_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [6:0]    shift, shift_nxt;
    logic          trd_q;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    mem [DEPTH];

    assign wr_data = {shift, sd};
    assign sbf     = (state == REQ);
    assign busy    = (state == REQ) || (state == WAIT_START) || (state == SHIFT);
    assign valid   = (state == DONE);

    // clr overrides every transition, including an abort in the middle of a frame
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        err_nxt     = err;
        tmo_nxt     = tmo;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        wr_en       = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            count_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trd && !trd_q) begin
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    tmo_nxt   = '0;
                    state_nxt = WAIT_START;
                end
                WAIT_START: begin
                    if (cd) begin
                        state_nxt = DONE;
                    end else if (sd && (count < FULL)) begin
                        state_nxt   = SHIFT;
                        bit_cnt_nxt = '0;
                    end else if (sd) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else if (tmo == TMO_LAST) begin
                        state_nxt = DONE;
                        if (count == '0) begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        tmo_nxt = tmo + 1'b1;
                    end
                end
                SHIFT: begin
                    shift_nxt   = {shift[5:0], sd};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        wr_en     = 1'b1;
                        tmo_nxt   = '0;
                        state_nxt = WAIT_START;
                        if (count < FULL) begin
                            count_nxt = count + 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            err     <= 1'b0;
            tmo     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            trd_q   <= 1'b0;
            rd_data <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            err     <= err_nxt;
            tmo     <= tmo_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            trd_q   <= trd;
            rd_data <= ({1'b0, rd_addr} < count) ? mem[rd_addr] : 8'h00;
        end
    end

    // Sample RAM has no reset; unwritten locations are masked by the count compare
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_tsc_dump_rx.sv
// Self-checking bench for tsc_dump_rx: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tsc_dump_rx;

    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 64;

    localparam int PH_IDLE  = 0;
    localparam int PH_REQ   = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_SHIFT = 3;
    localparam int PH_DONE  = 4;

    logic          clk;
    logic          reset;
    logic          trd;
    logic          cd;
    logic          sd;
    logic          sbf;
    logic          clr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   count;
    logic          busy;
    logic          valid;
    logic          err;

    int checks = 0;
    int errors = 0;

    tsc_dump_rx #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .trd     (trd),
        .cd      (cd),
        .sd      (sd),
        .sbf     (sbf),
        .clr     (clr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .busy    (busy),
        .valid   (valid),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model tracks the dump as phases, an idle-cycle count and a byte accumulator
    int         m_phase;
    int         m_idle;
    int         m_bits;
    int         m_acc;
    int         m_count;
    bit         m_err;
    bit         m_trd_prev;
    logic [7:0] m_rd;
    logic [7:0] m_mem [DEPTH];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase    = PH_IDLE;
            m_idle     = 0;
            m_bits     = 0;
            m_acc      = 0;
            m_count    = 0;
            m_err      = 1'b0;
            m_trd_prev = 1'b0;
            m_rd       = 8'h00;
        end else begin
            m_rd = (int'(rd_addr) < m_count) ? m_mem[rd_addr] : 8'h00;
            if (clr) begin
                m_phase = PH_IDLE;
                m_count = 0;
                m_err   = 1'b0;
            end else begin
                case (m_phase)
                    PH_IDLE: if (trd && !m_trd_prev) m_phase = PH_REQ;
                    PH_REQ: begin
                        m_idle  = 0;
                        m_phase = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (cd) m_phase = PH_DONE;
                        else if (sd) begin
                            if (m_count < DEPTH) begin
                                m_phase = PH_SHIFT;
                                m_bits  = 0;
                                m_acc   = 0;
                            end else begin
                                m_err   = 1'b1;
                                m_phase = PH_DONE;
                            end
                        end else if (m_idle + 1 >= TIMEOUT) begin
                            m_phase = PH_DONE;
                            if (m_count == 0) m_err = 1'b1;
                        end else m_idle++;
                    end
                    PH_SHIFT: begin
                        m_acc = (m_acc * 2 + int'(sd)) % 256;
                        m_bits++;
                        if (m_bits == 8) begin
                            m_mem[m_count] = 8'(m_acc);
                            m_count++;
                            m_idle  = 0;
                            m_phase = PH_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
            m_trd_prev = trd;
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_sbf",   int'(sbf),     int'(m_phase == PH_REQ));
        checkOutput("cyc_busy",  int'(busy),    int'(m_phase == PH_REQ || m_phase == PH_WAIT || m_phase == PH_SHIFT));
        checkOutput("cyc_valid", int'(valid),   int'(m_phase == PH_DONE));
        checkOutput("cyc_err",   int'(err),     int'(m_err));
        checkOutput("cyc_count", int'(count),   m_count);
        checkOutput("cyc_rd",    int'(rd_data), int'(m_rd));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic t, input logic c, input logic s, input logic k);
        trd = t;
        cd  = c;
        sd  = s;
        clr = k;
    endtask

    task automatic sendByte(input logic [7:0] b);
        sd = 1'b1;
        step(1);
        for (int i = 7; i >= 0; i--) begin
            sd = b[i];
            step(1);
        end
        sd = 1'b0;
    endtask

    task automatic startDump();
        trd = 1'b1;
        step(2);
        trd = 1'b0;
    endtask

    task automatic ackDump();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
    endtask

    task automatic finishDump();
        cd = 1'b1;
        step(1);
        cd = 1'b0;
        step(1);
    endtask

    task automatic readCheck(input string name, input int addr, input int expected);
        rd_addr = AW'(addr);
        step(1);
        checkOutput(name, int'(rd_data), expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        logic [7:0] b;
        reset   = 1'b0;
        rd_addr = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        checkOutput("rst_busy",  int'(busy),    0);
        checkOutput("rst_valid", int'(valid),   0);
        checkOutput("rst_count", int'(count),   0);
        checkOutput("rst_rd",    int'(rd_data), 0);
        reset = 1'b1;
        step(2);

        $display("[TB] T1 async reset mid-frame");
        startDump();
        sd = 1'b1;
        step(1);
        sd = 1'b0;
        step(3);
        checkOutput("t1_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        checkOutput("t1_busy",  int'(busy),  0);
        checkOutput("t1_sbf",   int'(sbf),   0);
        checkOutput("t1_err",   int'(err),   0);
        checkOutput("t1_count", int'(count), 0);
        step(2);
        reset = 1'b1;
        step(4);
        checkOutput("t1_idle_busy", int'(busy), 0);
        checkOutput("t1_idle_sbf",  int'(sbf),  0);

        $display("[TB] T2 single sbf pulse on held trd");
        trd = 1'b1;
        step(1);
        checkOutput("t2_sbf",  int'(sbf),  1);
        checkOutput("t2_busy", int'(busy), 1);
        pulses = 1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (sbf) pulses++;
        end
        checkOutput("t2_pulses", pulses, 1);
        trd = 1'b0;
        ackDump();

        $display("[TB] T3 three frames then cd");
        startDump();
        sendByte(8'hD5);
        sendByte(8'h01);
        sendByte(8'hFF);
        step(3);
        finishDump();
        checkOutput("t3_count", int'(count), 3);
        checkOutput("t3_valid", int'(valid), 1);
        checkOutput("t3_err",   int'(err),   0);
        readCheck("t3_rd0", 0, 8'hD5);
        readCheck("t3_rd1", 1, 8'h01);
        readCheck("t3_rd2", 2, 8'hFF);
        readCheck("t3_rd3", 3, 8'h00);
        ackDump();

        $display("[TB] T4 timeout with no bytes");
        startDump();
        step(TIMEOUT + 4);
        checkOutput("t4_valid", int'(valid), 1);
        checkOutput("t4_err",   int'(err),   1);
        checkOutput("t4_count", int'(count), 0);
        ackDump();
        checkOutput("t4_clr_err", int'(err), 0);

        $display("[TB] T5 overflow with back-to-back frames");
        startDump();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'((i * 37 + 5) % 256);
            sendByte(b);
        end
        step(2);
        checkOutput("t5_count", int'(count), DEPTH);
        checkOutput("t5_err",   int'(err),   1);
        checkOutput("t5_valid", int'(valid), 1);
        for (int i = 0; i < DEPTH; i++) begin
            readCheck("t5_rd", i, (i * 37 + 5) % 256);
        end
        ackDump();

        $display("[TB] T6 clr during second frame");
        startDump();
        sendByte(8'h3C);
        sd = 1'b1;
        step(1);
        sd = 1'b0;
        step(1);
        sd = 1'b1;
        step(2);
        clr = 1'b1;
        sd  = 1'b0;
        step(1);
        clr = 1'b0;
        checkOutput("t6_busy",  int'(busy),  0);
        checkOutput("t6_count", int'(count), 0);
        checkOutput("t6_valid", int'(valid), 0);
        step(2);
        startDump();
        sendByte(8'hA7);
        step(1);
        finishDump();
        checkOutput("t6_count_new", int'(count), 1);
        readCheck("t6_rd0", 0, 8'hA7);
        readCheck("t6_rd1", 1, 8'h00);
        ackDump();
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
